// File: rtl/grid_cell_tracker.sv
// Raster-to-grid tracker: follows pixelx/pixely through a COLS x ROWS cell grid with
// incremental counters, and keeps a button-driven cursor whose moves land at frame start.
module grid_cell_tracker #(
  parameter int COLS    = 3,
  parameter int ROWS    = 3,
  parameter int CELL_W  = 213,
  parameter int CELL_H  = 160,
  parameter int GRID_X0 = 0,
  parameter int GRID_Y0 = 0,
  parameter int SPR_DX  = 73,
  parameter int SPR_DY  = 47,
  parameter int BORDER  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] pixelx,
  input  logic [9:0] pixely,
  input  logic       mv_up,
  input  logic       mv_down,
  input  logic       mv_left,
  input  logic       mv_right,
  output logic       cell_valid,
  output logic [3:0] cell_col,
  output logic [3:0] cell_row,
  output logic [7:0] cell_index,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic [9:0] offx,
  output logic [9:0] offy,
  output logic       on_border,
  output logic [7:0] cursor_index,
  output logic       cursor_hit
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  localparam logic [9:0] X0    = 10'(GRID_X0);
  localparam logic [9:0] Y0    = 10'(GRID_Y0);
  localparam logic [9:0] PX0   = 10'((GRID_X0 + SPR_DX) % 1024);
  localparam logic [9:0] PY0   = 10'((GRID_Y0 + SPR_DY) % 1024);
  localparam logic [9:0] CW    = 10'(CELL_W % 1024);
  localparam logic [9:0] CH    = 10'(CELL_H % 1024);
  localparam logic [9:0] CW_M1 = 10'(CELL_W - 1);
  localparam logic [9:0] CH_M1 = 10'(CELL_H - 1);
  localparam logic [9:0] BD    = 10'(BORDER);
  localparam logic [9:0] BX_HI = 10'(CELL_W - BORDER);
  localparam logic [9:0] BY_HI = 10'(CELL_H - BORDER);
  localparam logic [3:0] COL_M1 = 4'(COLS - 1);
  localparam logic [3:0] ROW_M1 = 4'(ROWS - 1);
  localparam logic [7:0] NCOL   = 8'(COLS);
  localparam logic [7:0] LAST_BASE = 8'((ROWS - 1) * COLS);

  logic       x_in_q, x_in_d, y_in_q, y_in_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic [9:0] offx_q, offx_d, offy_q, offy_d, posx_q, posx_d, posy_q, posy_d;
  logic [7:0] rbase_q, rbase_d;

  logic [0:0] st_q, st_d;
  logic [1:0] dir_q, dir_d;
  logic [3:0] cur_col_q, cur_col_d, cur_row_q, cur_row_d;
  logic [7:0] cur_base_q, cur_base_d;

  logic       valid_d, border_d, hit_d, frame_start;
  logic [7:0] idx_d, cidx_d;

  // rbase tracks row*COLS so neither index needs a multiplier
  always_comb begin
    x_in_d = x_in_q; col_d = col_q; offx_d = offx_q; posx_d = posx_q;
    y_in_d = y_in_q; row_d = row_q; offy_d = offy_q; posy_d = posy_q; rbase_d = rbase_q;
    if (pix_en) begin
      if (pixelx == X0) begin
        x_in_d = 1'b1; col_d = 4'd0; offx_d = 10'd0; posx_d = PX0;
      end else if (x_in_q) begin
        if (offx_q == CW_M1) begin
          offx_d = 10'd0;
          if (col_q == COL_M1) x_in_d = 1'b0;
          else begin col_d = col_q + 4'd1; posx_d = posx_q + CW; end
        end else offx_d = offx_q + 10'd1;
      end
      if (pixelx == 10'd0) begin
        if (pixely == Y0) begin
          y_in_d = 1'b1; row_d = 4'd0; offy_d = 10'd0; posy_d = PY0; rbase_d = 8'd0;
        end else if (y_in_q) begin
          if (offy_q == CH_M1) begin
            offy_d = 10'd0;
            if (row_q == ROW_M1) y_in_d = 1'b0;
            else begin row_d = row_q + 4'd1; posy_d = posy_q + CH; rbase_d = rbase_q + NCOL; end
          end else offy_d = offy_q + 10'd1;
        end
      end
    end
  end

  assign frame_start = pix_en & (pixelx == 10'd0) & (pixely == 10'd0);

  always_comb begin
    st_d = st_q; dir_d = dir_q;
    cur_col_d = cur_col_q; cur_row_d = cur_row_q; cur_base_d = cur_base_q;
    if (st_q == IDLE) begin
      if (mv_up | mv_down | mv_left | mv_right) begin
        st_d  = PENDING;
        dir_d = mv_up ? 2'd0 : mv_down ? 2'd1 : mv_left ? 2'd2 : 2'd3;
      end
    end else if (frame_start) begin
      st_d = IDLE;
      case (dir_q)
        2'd0: if (cur_row_q == 4'd0) begin cur_row_d = ROW_M1; cur_base_d = LAST_BASE; end
              else begin cur_row_d = cur_row_q - 4'd1; cur_base_d = cur_base_q - NCOL; end
        2'd1: if (cur_row_q == ROW_M1) begin cur_row_d = 4'd0; cur_base_d = 8'd0; end
              else begin cur_row_d = cur_row_q + 4'd1; cur_base_d = cur_base_q + NCOL; end
        2'd2: cur_col_d = (cur_col_q == 4'd0) ? COL_M1 : cur_col_q - 4'd1;
        default: cur_col_d = (cur_col_q == COL_M1) ? 4'd0 : cur_col_q + 4'd1;
      endcase
    end
  end

  // hit compares against the post-move cursor so pixel (0,0) already sees it
  assign valid_d  = x_in_d & y_in_d;
  assign idx_d    = rbase_d + {4'd0, col_d};
  assign cidx_d   = cur_base_d + {4'd0, cur_col_d};
  assign border_d = valid_d & ((offx_d < BD) | (offx_d >= BX_HI) | (offy_d < BD) | (offy_d >= BY_HI));
  assign hit_d    = valid_d & (idx_d == cidx_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_in_q <= 1'b0; col_q <= '0; offx_q <= '0; posx_q <= '0;
      y_in_q <= 1'b0; row_q <= '0; offy_q <= '0; posy_q <= '0; rbase_q <= '0;
      st_q <= IDLE; dir_q <= '0; cur_col_q <= '0; cur_row_q <= '0; cur_base_q <= '0;
      cell_valid <= 1'b0; cell_col <= '0; cell_row <= '0; cell_index <= '0;
      posx <= '0; posy <= '0; offx <= '0; offy <= '0;
      on_border <= 1'b0; cursor_hit <= 1'b0; cursor_index <= '0;
    end else begin
      x_in_q <= x_in_d; col_q <= col_d; offx_q <= offx_d; posx_q <= posx_d;
      y_in_q <= y_in_d; row_q <= row_d; offy_q <= offy_d; posy_q <= posy_d; rbase_q <= rbase_d;
      st_q <= st_d; dir_q <= dir_d; cur_col_q <= cur_col_d; cur_row_q <= cur_row_d;
      cur_base_q <= cur_base_d;
      cursor_index <= cidx_d;
      if (pix_en) begin
        cell_valid <= valid_d;
        on_border  <= border_d;
        cursor_hit <= hit_d;
        if (valid_d) begin
          cell_col <= col_d; cell_row <= row_d; cell_index <= idx_d;
          posx <= posx_d; posy <= posy_d; offx <= offx_d; offy <= offy_d;
        end
      end
    end
  end
endmodule
